// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path.
// The immediate extender and ALU decoder use these same constants.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_ZERO = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IOP   = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP
    } state_e;

    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
               (op == OP_ANDI) || (op == OP_ORI)   || (op == OP_XORI) ||
               (op == OP_LUI);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_LW) || (op == OP_SW) || is_itype(op);
    endfunction

    function automatic logic [1:0] ext_mode_of(input logic [5:0] op);
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
            return EXT_ZERO;
        if (op == OP_LUI)
            return EXT_LUI;
        return EXT_SIGN;
    endfunction

endpackage

// File: rtl/mc_ctrl_out.sv
// Control-word decoder: state plus opcode to datapath strobes and mux selects.
// Write/request strobes are squashed while reset is asserted.
module mc_ctrl_out
    import mips_pkg::*;
(
    input  state_e      state_i,
    input  logic [5:0]  op_q_i,
    input  logic [5:0]  opcode_i,
    input  logic        mem_ready_i,
    input  logic        rst_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        iord_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_write_cond_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  pc_src_o,
    output logic [1:0]  ext_mode_o,
    output logic        illegal_op_o
);

    always_comb begin
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        iord_o          = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_B;
        alu_op_o        = ALU_ADD;
        pc_src_o        = PC_ALU;
        illegal_op_o    = 1'b0;
        ext_mode_o      = ext_mode_of((state_i == S_DECODE) ? opcode_i : op_q_i);

        case (state_i)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o  = SRCB_IMM_SH2;
                illegal_op_o = !is_legal(opcode_i);
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_IOP;
            end
            S_I_WB: begin
                reg_write_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALU_SUB;
                pc_src_o        = PC_ALUOUT;
                pc_write_cond_o = 1'b1;
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = PC_JUMP;
            end
            default: ;
        endcase

        if (rst_i) begin
            mem_req_o       = 1'b0;
            mem_we_o        = 1'b0;
            ir_write_o      = 1'b0;
            pc_write_o      = 1'b0;
            pc_write_cond_o = 1'b0;
            reg_write_o     = 1'b0;
            illegal_op_o    = 1'b0;
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle instruction sequencer: state register, opcode register and
// next-state logic; the control word itself comes from mc_ctrl_out.
module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [1:0]  ext_mode,
    output logic        illegal_op
);

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;

    // The branch decision is taken in the datapath (pc_write_cond & zero).
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= OP_RTYPE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = opcode;
                if (opcode == OP_RTYPE)
                    state_d = S_EXEC_R;
                else if (opcode == OP_LW || opcode == OP_SW)
                    state_d = S_MEM_ADDR;
                else if (opcode == OP_BEQ)
                    state_d = S_BRANCH;
                else if (opcode == OP_J)
                    state_d = S_JUMP;
                else if (is_itype(opcode))
                    state_d = S_EXEC_I;
                else
                    state_d = S_FETCH;
            end
            S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    mc_ctrl_out u_out (
        .state_i         (state_q),
        .op_q_i          (op_q),
        .opcode_i        (opcode),
        .mem_ready_i     (mem_ready),
        .rst_i           (rst),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .iord_o          (iord),
        .ir_write_o      (ir_write),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .reg_write_o     (reg_write),
        .reg_dst_o       (reg_dst),
        .mem_to_reg_o    (mem_to_reg),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .pc_src_o        (pc_src),
        .ext_mode_o      (ext_mode),
        .illegal_op_o    (illegal_op)
    );

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: per-cycle expected control words are
// queued as stimulus is driven and compared at the following falling edge.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        zero;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_src, ext_mode;

    int          checks = 0;
    int          errors = 0;
    logic [18:0] sb[$];
    logic [5:0]  last_op;

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .ext_mode(ext_mode), .illegal_op(illegal_op)
    );

    wire [18:0] obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                       reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                       alu_op, pc_src, ext_mode, illegal_op};

    function automatic logic [18:0] cw(
        input logic req, we, io, irw, pcw, pwc, rw, rdst, m2r, sa,
        input logic [1:0] sb_, aop, psrc, ext, input logic ill);
        return {req, we, io, irw, pcw, pwc, rw, rdst, m2r, sa, sb_, aop, psrc, ext, ill};
    endfunction

    function automatic logic [1:0] ext_of(input logic [5:0] op);
        case (op)
            6'b001100, 6'b001101, 6'b001110: return 2'b01;
            6'b001111:                       return 2'b10;
            default:                         return 2'b00;
        endcase
    endfunction

    function automatic logic legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000010, 6'b000100, 6'b100011, 6'b101011,
            6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101,
            6'b001110, 6'b001111: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    // Runs one instruction from FETCH; fwait/mwait are memory wait cycles.
    task automatic run_instr(input string name, input logic [5:0] op,
                             input int fwait, input int mwait, input logic z);
        logic [18:0] tr_e[$];
        logic        tr_r[$];
        logic [18:0] e, got;
        logic [1:0]  x;
        int          didx;
        x = ext_of(op);
        for (int i = 0; i < fwait; i++) begin
            tr_r.push_back(1'b0);
            tr_e.push_back(cw(1,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,ext_of(last_op),0));
        end
        tr_r.push_back(1'b1);
        tr_e.push_back(cw(1,0,0,1,1,0,0,0,0,0,2'b01,2'b00,2'b00,ext_of(last_op),0));
        didx = tr_r.size();
        tr_r.push_back(1'b1);
        tr_e.push_back(cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,x,!legal(op)));
        if (op == 6'b100011 || op == 6'b101011) begin
            tr_r.push_back(1'b1);
            tr_e.push_back(cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,x,0));
            for (int i = 0; i <= mwait; i++) begin
                tr_r.push_back(i == mwait);
                tr_e.push_back(cw(1,(op == 6'b101011),1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,x,0));
            end
            if (op == 6'b100011) begin
                tr_r.push_back(1'b1);
                tr_e.push_back(cw(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,x,0));
            end
        end else if (op == 6'b000000) begin
            tr_r.push_back(1'b1);
            tr_e.push_back(cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,x,0));
            tr_r.push_back(1'b1);
            tr_e.push_back(cw(0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,x,0));
        end else if (op == 6'b000100) begin
            tr_r.push_back(1'b1);
            tr_e.push_back(cw(0,0,0,0,0,1,0,0,0,1,2'b00,2'b01,2'b01,x,0));
        end else if (op == 6'b000010) begin
            tr_r.push_back(1'b1);
            tr_e.push_back(cw(0,0,0,0,1,0,0,0,0,0,2'b00,2'b00,2'b10,x,0));
        end else if (legal(op)) begin
            tr_r.push_back(1'b1);
            tr_e.push_back(cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,x,0));
            tr_r.push_back(1'b1);
            tr_e.push_back(cw(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,x,0));
        end
        for (int i = 0; i < tr_r.size(); i++) begin
            @(posedge clk);
            #1;
            mem_ready = tr_r[i];
            zero      = z;
            opcode    = (i == didx) ? op : 6'($urandom_range(0, 63));
            sb.push_back(tr_e[i]);
            @(negedge clk);
            got = obs;
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, i, got, e);
            end
        end
        last_op = op;
    endtask

    task automatic test_reset();
        logic [18:0] e, got;
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            sb.push_back(cw(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,0));
            @(negedge clk);
            got = obs;
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, got, e);
            end
        end
        last_op   = 6'b000000;
        rst       = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_fetch_wait();
        run_instr("fetch_wait_rtype", 6'b000000, 3, 0, 1'b0);
    endtask

    task automatic test_lw();
        run_instr("lw_zero_wait", 6'b100011, 0, 0, 1'b0);
        run_instr("lw_two_wait", 6'b100011, 1, 2, 1'b0);
    endtask

    task automatic test_ext_modes();
        run_instr("ori", 6'b001101, 0, 0, 1'b0);
        run_instr("lui", 6'b001111, 0, 0, 1'b0);
        run_instr("addiu", 6'b001001, 0, 0, 1'b0);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", 6'b000100, 0, 0, 1'b1);
        run_instr("beq_not_taken", 6'b000100, 0, 0, 1'b0);
        run_instr("jump", 6'b000010, 0, 0, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_3f", 6'b111111, 0, 0, 1'b0);
        run_instr("sw_after_illegal", 6'b101011, 0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [8];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001110,
                6'b000100, 6'b000010, 6'b010001};
        for (int i = 0; i < 10; i++)
            run_instr("b2b", ops[$urandom_range(0, 7)], $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    endtask

    // sw aborted by reset while MEM_WR is waiting for memory.
    task automatic test_sw_reset();
        logic [18:0] tr_e[$];
        logic        tr_r[$];
        logic        tr_rst[$];
        logic [5:0]  tr_op[$];
        logic [18:0] e, got;
        tr_r.push_back(1); tr_rst.push_back(0); tr_op.push_back(6'b000000);
        tr_e.push_back(cw(1,0,0,1,1,0,0,0,0,0,2'b01,2'b00,2'b00,ext_of(last_op),0));
        tr_r.push_back(1); tr_rst.push_back(0); tr_op.push_back(6'b101011);
        tr_e.push_back(cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,2'b00,0));
        tr_r.push_back(1); tr_rst.push_back(0); tr_op.push_back(6'b001101);
        tr_e.push_back(cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,0));
        tr_r.push_back(0); tr_rst.push_back(0); tr_op.push_back(6'b001101);
        tr_e.push_back(cw(1,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
        tr_r.push_back(1); tr_rst.push_back(1); tr_op.push_back(6'b001101);
        tr_e.push_back(cw(0,0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
        tr_r.push_back(1); tr_rst.push_back(1); tr_op.push_back(6'b001101);
        tr_e.push_back(cw(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,0));
        tr_r.push_back(0); tr_rst.push_back(0); tr_op.push_back(6'b001101);
        tr_e.push_back(cw(1,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,0));
        for (int i = 0; i < tr_r.size(); i++) begin
            @(posedge clk);
            #1;
            mem_ready = tr_r[i];
            rst       = tr_rst[i];
            opcode    = tr_op[i];
            sb.push_back(tr_e[i]);
            @(negedge clk);
            got = obs;
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL sw_reset cycle %0d: got %b expected %b", i, got, e);
            end
        end
        last_op = 6'b000000;
        run_instr("after_sw_reset", 6'b001100, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_lw();
        test_ext_modes();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_sw_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control FSM for the 32-bit MIPS-subset core, the multi-cycle counterpart of the single-cycle main decoder. It sequences one instruction over 3-5 states and a variable number of memory-wait cycles. It drives every datapath strobe: PC, IR, register-file write, memory request, ALU operand muxes and ALU-op class. It also drives `ext_mode`, which selects sign-, zero- or upper-immediate extension for the immediate extender.

## Interface
- No parameters.
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — synchronous, active-high reset.
- `opcode` in 6 — IR[31:26]; sampled in DECODE only.
- `mem_ready` in 1 — memory completion for the current request; may stay high or arrive after any number of cycles.
- `zero` in 1 — ALU zero flag; used in BRANCH.
- `mem_req` out 1 — memory access request.
- `mem_we` out 1 — write qualifier for `mem_req`.
- `iord` out 1 — memory address source: 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `pc_write_cond`, `reg_write` out 1 each — write strobes.
- `reg_dst` out 1 — destination register: 0 = rt, 1 = rd.
- `mem_to_reg` out 1 — write-back source: 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1 — 0 = PC, 1 = A.
- `alu_src_b` out 2 — 00 = B, 01 = const 4, 10 = ext_imm, 11 = ext_imm<<2.
- `alu_op` out 2 — 00 = add, 01 = sub, 10 = R-type funct, 11 = I-type op.
- `pc_src` out 2 — 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ext_mode` out 2 — 00 = sign, 01 = zero, 10 = lui (imm<<16).
- `illegal_op` out 1 — one-cycle pulse on an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP.
- FETCH:
  - Outputs: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1 (Mealy), and that cycle moves to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut).
  - Next state by `opcode`:
    - 000000 → EXEC_R
    - 100011 (lw) / 101011 (sw) → MEM_ADDR
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - 001000/001001/001010/001100/001101/001110/001111 (addi/addiu/slti/andi/ori/xori/lui) → EXEC_I
    - Any other opcode → FETCH, with `illegal_op`=1 for this cycle.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Go to MEM_RD for lw, MEM_WR for sw. The opcode is held in an internal register captured in DECODE.
- MEM_RD: `mem_req`=1, `iord`=1. Wait for `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1; then FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1. Wait for `mem_ready`, then go to FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10; then R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0; then FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11; then I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0; then FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `pc_write_cond`=1. The datapath writes the PC when `zero`=1. Then FETCH.
- JUMP: `pc_write`=1, `pc_src`=10; then FETCH.
- `ext_mode` is driven from the registered opcode in every state after DECODE, and from `opcode` in DECODE:
  - 01 for andi/ori/xori
  - 10 for lui
  - 00 otherwise, including addiu, which sign-extends.
- Every output not listed for a state is 0.

## Timing
- State register updates on `posedge clk`. All outputs are combinational from the state and the registered opcode. Exceptions: the FETCH Mealy terms and the DECODE terms, which also use the inputs.
- Reset: the cycle after `rst`=1 the state is FETCH. While `rst`=1, `ir_write`, `pc_write`, `pc_write_cond`, `reg_write`, `mem_req`, `mem_we` and `illegal_op` are forced to 0.
- Reset mid-instruction (including during a memory wait) aborts it. No write strobe fires after `rst` is sampled.
- Latency with zero-wait memory (`mem_ready` high in the first request cycle):
  - lw: 5 cycles
  - sw, R-type, I-type: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each wait cycle adds one. `mem_req` stays high through the wait and drops the cycle after `mem_ready` is sampled high. `mem_ready` seen while `mem_req`=0 is ignored.

## Structure
- Shared package `mips_pkg`:
  - opcode constants
  - `ext_mode`, `alu_op`, `alu_src_b` and `pc_src` encodings; the immediate extender and ALU decoder use the same constants
  - state enum
- One sub-module: `mc_ctrl_out`, the combinational state/opcode → control-word decoder. The top holds the state register, the opcode register and the next-state logic.

## Test plan
- Reset, then `rst`=0 with `mem_ready`=0 for 3 cycles → FETCH held, `mem_req`=1, `ir_write`=0. On `mem_ready`=1 → `ir_write`=`pc_write`=1 for one cycle, then DECODE.
- lw (100011) with `mem_ready` always 1 → FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. `reg_write`=1, `mem_to_reg`=1 only in cycle 5.
- ori (001101), then lui (001111), then addiu (001001) → `ext_mode` = 01, 10, 00 respectively during EXEC_I/I_WB. `reg_dst`=0 on write-back.
- beq with `zero`=1, then beq with `zero`=0 → `pc_write_cond`=1, `pc_src`=01 in BRANCH both times. 3-cycle instruction each time.
- Opcode 111111 → `illegal_op`=1 for exactly the DECODE cycle, back to FETCH. No `reg_write` or `mem_req` beyond fetch.
- sw with `rst` asserted during the MEM_WR wait → next state FETCH, `mem_we` never high after `rst` is sampled.
